multiplier_seq_n_bits: RTL and testbench
========================================

Name: multiplier_seq_N_bits

Overview:
- Iterative shift-add multiplier. It replaces the flat array multiplier where area matters more than latency.
- Computes an N x N product in N+1 clocks and supports unsigned and two's-complement operands.
- Optional accumulate mode turns it into a multiply-accumulate unit with sticky overflow.
- Sits between the operand registers and the result/display path, with a start/busy/done handshake.

Parameters:
N, 8, operand width in bits (N >= 2); product/accumulator width is 2*N.

Ports:
clk    input   1     rising-edge clock
aclr   input   1     synchronous active-low reset, sampled on rising edge of clk
start  input   1     request new operation; sampled only in IDLE
a      input   N     multiplicand, sampled with start
b      input   N     multiplier, sampled with start
sgn    input   1     1 = a, b are two's complement; 0 = unsigned; sampled with start
acc_en input   1     1 = p <= p + a*b; 0 = p <= a*b; sampled with start
busy   output  1     operation in progress
done   output  1     one-cycle pulse, p updated
p      output  2*N   result / accumulator register
ovf    output  1     sticky accumulate overflow

Behaviour:
- Reset (aclr=0 at rising edge): state=IDLE, p=0, busy=0, done=0, ovf=0, all internal registers cleared. Reset mid-operation aborts it; no done pulse and p is not written.
- States: IDLE, RUN, FIX.
- IDLE:
  - done=0.
  - On an edge with start=1: latch sgn and acc_en.
  - When sgn=1, latch magnitudes |a| and |b| as N-bit unsigned values (|-2^(N-1)| = 2^(N-1) fits) and neg = a[N-1]^b[N-1]. When sgn=0, latch a and b as-is with neg=0.
  - Clear the 2N-bit partial register, counter=0, busy<=1, go to RUN.
- RUN, one step per edge, N edges:
  - If the multiplier LSB is 1, add the multiplicand into the upper N+1 bits of partial.
  - Shift partial right 1 and shift the multiplier right 1; counter++.
  - After the Nth step, go to FIX.
- FIX, single edge:
  - prod = neg ? -partial : partial, in 2N-bit two's complement. A zero product never produces a negative zero.
  - acc_en=0: p<=prod, ovf<=0.
  - acc_en=1: p<=p+prod, modulo 2^(2N).
    - Unsigned: ovf<=ovf | carry-out.
    - Signed: ovf<=ovf | (sign(p)==sign(prod) && sign(sum)!=sign(p)).
  - busy<=0, done<=1, go to IDLE.
- Latency:
  - Start sampled at edge E0.
  - busy=1 after E0.
  - p valid, done=1, busy=0 after edge E0+N+1.
  - done clears after E0+N+2 unless a new op completes then (not possible).
  - Earliest next start is sampled at E0+N+2, so back-to-back throughput is one op per N+2 edges.
- start while busy (RUN/FIX) is ignored: no queueing, no effect on the current op. Holding start high continuously issues back-to-back ops.
- a, b, sgn and acc_en may change freely after the start edge.
- p holds its value between operations. In signed mode p is read as two's complement.

Test Plan:
- N=8, unsigned: start with a=0xFF, b=0xFF, sgn=0, acc_en=0 -> busy for 9 edges; done pulses exactly once after edge E0+9; p=0xFE01; ovf=0.
- Signed, two ops: sgn=1, a=0x80, b=0x80 -> p=0x4000. Then a=0xFD (-3), b=0x05 -> p=0xFFF1. Then a=0x00, b=0x80 -> p=0x0000.
- Accumulate: unsigned 0xFF*0xFF with acc_en=0 -> p=0xFE01. Then 100*100 with acc_en=1 -> p=0x2511 (75025 mod 65536), ovf=1. Then 1*1 with acc_en=1 -> p=0x2512, ovf still 1. Then 2*3 with acc_en=0 -> p=0x0006, ovf=0.
- Signed accumulate: p=0x7FFF established, then 0x01*0x01 with sgn=1, acc_en=1 -> p=0x8000, ovf=1.
- Handshake:
  - Pulse start with a=3, b=4, then pulse start again with a=5, b=6 at E0+3 -> second request ignored; p=0x000C; single done pulse.
  - Then hold start high with a=2, b=2 -> done pulses every 10 edges; p=0x0004 each time.
- Reset mid-op: after p=0x000C, start a=0xFF, b=0xFF, then drive aclr=0 at E0+4 -> p=0, busy=0, done=0, ovf=0 immediately after that edge; no later done pulse. A subsequent op completes normally.

Source files
------------

// File: rtl/multiplier_seq_n_bits.sv
`default_nettype none
// ============================================================================
// Module      : multiplier_seq_n_bits
// Description : Iterative shift-add N x N multiplier with signed/unsigned
//               operands and optional accumulate with sticky overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module multiplier_seq_n_bits #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           aclr,
    input  logic           start,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    input  logic           sgn,
    input  logic           acc_en,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] p,
    output logic           ovf
);

    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] C_LAST_STEP = CW'(N - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_next;

    logic [N-1:0]   r_mcand;
    logic [N-1:0]   r_mplier;
    logic [2*N-1:0] r_partial;
    logic [CW-1:0]  r_cnt;
    logic           r_neg;
    logic           r_sgn;
    logic           r_acc;

    logic [N-1:0]   w_mag_a;
    logic [N-1:0]   w_mag_b;
    logic [N:0]     w_add;
    logic [2*N-1:0] w_prod;
    logic [2*N:0]   w_sum;
    logic           w_sovf;

    // Magnitude of the most negative value wraps to itself, which is exactly
    // 2^(N-1) when read as unsigned.
    assign w_mag_a = (sgn && a[N-1]) ? -a : a;
    assign w_mag_b = (sgn && b[N-1]) ? -b : b;

    assign w_add  = {1'b0, r_partial[2*N-1:N]} + (r_mplier[0] ? {1'b0, r_mcand} : '0);
    assign w_prod = r_neg ? -r_partial : r_partial;
    assign w_sum  = {1'b0, p} + {1'b0, w_prod};
    assign w_sovf = (p[2*N-1] == w_prod[2*N-1]) && (w_sum[2*N-1] != p[2*N-1]);

    always_ff @(posedge clk) begin
        if (!aclr) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (start) w_next = ST_RUN;
            ST_RUN:  if (r_cnt == C_LAST_STEP) w_next = ST_FIX;
            ST_FIX:  w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!aclr) begin
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_partial <= '0;
            r_cnt     <= '0;
            r_neg     <= 1'b0;
            r_sgn     <= 1'b0;
            r_acc     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            p         <= '0;
            ovf       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_sgn     <= sgn;
                        r_acc     <= acc_en;
                        r_mcand   <= w_mag_a;
                        r_mplier  <= w_mag_b;
                        r_neg     <= sgn & (a[N-1] ^ b[N-1]);
                        r_partial <= '0;
                        r_cnt     <= '0;
                        busy      <= 1'b1;
                    end
                end
                ST_RUN: begin
                    r_partial <= {w_add, r_partial[N-1:1]};
                    r_mplier  <= r_mplier >> 1;
                    r_cnt     <= r_cnt + 1'b1;
                end
                ST_FIX: begin
                    if (r_acc) begin
                        p   <= w_sum[2*N-1:0];
                        ovf <= ovf | (r_sgn ? w_sovf : w_sum[2*N]);
                    end else begin
                        p   <= w_prod;
                        ovf <= 1'b0;
                    end
                    busy <= 1'b0;
                    done <= 1'b1;
                end
                default: begin
                    busy <= 1'b0;
                    done <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_multiplier_seq_n_bits.sv
`default_nettype none
// ============================================================================
// Module      : tb_multiplier_seq_n_bits
// Description : Self-checking bench for multiplier_seq_n_bits (N = 8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multiplier_seq_n_bits;

    localparam int N = 8;

    logic           clk = 1'b0;
    logic           aclr;
    logic           start;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic           sgn;
    logic           acc_en;
    logic           busy;
    logic           done;
    logic [2*N-1:0] p;
    logic           ovf;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] m_p   = '0;
    logic        m_ovf = 1'b0;

    multiplier_seq_n_bits #(.N(N)) u_dut (
        .clk    (clk),
        .aclr   (aclr),
        .start  (start),
        .a      (a),
        .b      (b),
        .sgn    (sgn),
        .acc_en (acc_en),
        .busy   (busy),
        .done   (done),
        .p      (p),
        .ovf    (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: integer arithmetic on the operand values.
    task automatic model_op(input logic [7:0] ma, input logic [7:0] mb,
                            input logic ms, input logic macc);
        int av, bv, pr, sp, sq;
        logic [15:0] prod;
        av   = ms ? int'($signed(ma)) : int'(ma);
        bv   = ms ? int'($signed(mb)) : int'(mb);
        pr   = av * bv;
        prod = pr[15:0];
        if (!macc) begin
            m_p   = prod;
            m_ovf = 1'b0;
        end else begin
            if (!ms) begin
                if (int'(m_p) + int'(prod) > 65535) m_ovf = 1'b1;
            end else begin
                sp = int'($signed(m_p));
                sq = int'($signed(prod));
                if (sp + sq > 32767 || sp + sq < -32768) m_ovf = 1'b1;
            end
            m_p = m_p + prod;
        end
    endtask

    task automatic do_op(input logic [7:0] ta, input logic [7:0] tb,
                         input logic ts, input logic tacc);
        int n;
        @(negedge clk);
        a = ta; b = tb; sgn = ts; acc_en = tacc; start = 1'b1;
        @(posedge clk);
        #1;
        check("busy_after_start", busy, 1);
        @(negedge clk);
        start = 1'b0;
        a = 8'($urandom); b = 8'($urandom); sgn = 1'($urandom); acc_en = 1'($urandom);
        for (n = 1; n <= 20; n++) begin
            if (n > 1) @(posedge clk);
            else @(posedge clk);
            #1;
            if (done) break;
        end
        check("latency", n, N + 1);
        model_op(ta, tb, ts, tacc);
        check("p", p, m_p);
        check("ovf", ovf, m_ovf);
        check("busy_at_done", busy, 0);
        @(posedge clk);
        #1;
        check("done_pulse_clear", done, 0);
    endtask

    initial begin
        int ndone, tdone, tprev;
        aclr = 1'b0; start = 1'b0; a = '0; b = '0; sgn = 1'b0; acc_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_p", p, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ovf", ovf, 0);
        @(negedge clk);
        aclr = 1'b1;

        // Unsigned full-scale
        do_op(8'hFF, 8'hFF, 1'b0, 1'b0);
        check("plan_ff_ff", p, 16'hFE01);

        // Signed
        do_op(8'h80, 8'h80, 1'b1, 1'b0);
        check("plan_s_80_80", p, 16'h4000);
        do_op(8'hFD, 8'h05, 1'b1, 1'b0);
        check("plan_s_m3_5", p, 16'hFFF1);
        do_op(8'h00, 8'h80, 1'b1, 1'b0);
        check("plan_s_zero", p, 16'h0000);

        // Accumulate
        do_op(8'hFF, 8'hFF, 1'b0, 1'b0);
        do_op(8'd100, 8'd100, 1'b0, 1'b1);
        check("plan_acc1", p, 16'h2511);
        check("plan_acc1_ovf", ovf, 1);
        do_op(8'd1, 8'd1, 1'b0, 1'b1);
        check("plan_acc2", p, 16'h2512);
        check("plan_acc2_ovf", ovf, 1);
        do_op(8'd2, 8'd3, 1'b0, 1'b0);
        check("plan_acc3", p, 16'h0006);
        check("plan_acc3_ovf", ovf, 0);

        // Signed accumulate overflow: 151*217 = 0x7FFF
        do_op(8'd151, 8'd217, 1'b0, 1'b0);
        check("plan_7fff", p, 16'h7FFF);
        do_op(8'h01, 8'h01, 1'b1, 1'b1);
        check("plan_sacc", p, 16'h8000);
        check("plan_sacc_ovf", ovf, 1);

        // Start while busy is ignored
        @(negedge clk);
        a = 8'd3; b = 8'd4; sgn = 1'b0; acc_en = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk); start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk); a = 8'd5; b = 8'd6; start = 1'b1;
        @(posedge clk);
        @(negedge clk); start = 1'b0;
        ndone = 0; tdone = 0;
        for (int k = 4; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                ndone++;
                tdone = k;
            end
        end
        model_op(8'd3, 8'd4, 1'b0, 1'b0);
        check("ignore_ndone", ndone, 1);
        check("ignore_edge", tdone, N + 1);
        check("ignore_p", p, 16'h000C);

        // Start held high: back-to-back ops every N+2 edges
        @(negedge clk);
        a = 8'd2; b = 8'd2; sgn = 1'b0; acc_en = 1'b0; start = 1'b1;
        tprev = -1;
        for (int op = 0; op < 3; op++) begin
            tdone = -1;
            for (int k = 0; k < 20; k++) begin
                @(posedge clk);
                #1;
                if (done) begin
                    tdone = k + 1;
                    break;
                end
            end
            check("hold_done_seen", (tdone > 0), 1);
            if (op > 0) check("hold_interval", tdone, N + 2);
            check("hold_p", p, 16'h0004);
            tprev = tdone;
        end
        start = 1'b0;
        model_op(8'd2, 8'd2, 1'b0, 1'b0);
        repeat (N + 4) @(posedge clk);

        // Reset mid-operation
        do_op(8'd3, 8'd4, 1'b0, 1'b0);
        @(negedge clk);
        a = 8'hFF; b = 8'hFF; start = 1'b1;
        @(posedge clk);
        @(negedge clk); start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); aclr = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_p", p, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_ovf", ovf, 0);
        @(negedge clk); aclr = 1'b1;
        ndone = 0;
        for (int k = 0; k < 15; k++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        check("midrst_no_done", ndone, 0);
        m_p = '0; m_ovf = 1'b0;
        do_op(8'd7, 8'd9, 1'b0, 1'b0);

        // Randomized operations against the model
        for (int i = 0; i < 60; i++) begin
            do_op(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom_range(0, 2) != 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
